// File: rtl/mcu_bank_sequencer.sv
// rtl/mcu_bank_sequencer.sv - load/run/read sequencer for the MCU bank and convolver routing array
module mcu_bank_sequencer #(
    parameter int N         = 2,
    parameter int BITS_ADDR = 10,
    parameter int CONV_LAT  = 4,
    localparam int SUB_W    = $clog2(N / 2 + 1),
    localparam int SEL_W    = $clog2(N + 2)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_restart,
    input  logic [BITS_ADDR-1:0] i_width,
    input  logic                 i_valid,
    input  logic                 i_rd_ready,
    output logic [1:0]           o_state,
    output logic [SUB_W-1:0]     o_substate,
    output logic [SEL_W-1:0]     o_memSelect,
    output logic [N+1:0]         o_wr_en,
    output logic [BITS_ADDR-1:0] o_wr_addr,
    output logic [BITS_ADDR-1:0] o_rd_addr,
    output logic                 o_conv_valid,
    output logic                 o_ready,
    output logic                 o_data_valid,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int RUN_W = $clog2((1 << BITS_ADDR) + CONV_LAT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_READ, S_DRAIN} state_t;

    state_t               state;
    logic [SUB_W-1:0]     substate;
    logic                 full;
    logic                 load_full;
    logic [SEL_W-1:0]     idx;
    logic [BITS_ADDR-1:0] col;
    logic [BITS_ADDR-1:0] width_r;
    logic [RUN_W-1:0]     run_cnt;
    logic [SEL_W-1:0]     sel_q;
    logic                 data_valid_q;
    logic                 done_q;

    // Incremental loads refill only the N banks that rotate into the window for the new substate.
    function automatic logic [SEL_W-1:0] load_bank(input logic [SEL_W-1:0] k,
                                                   input logic [SUB_W-1:0] z,
                                                   input logic full_m);
        int b;
        if (full_m) begin
            b = int'(k);
        end else begin
            b = 2 - 2 * int'(z) + int'(k) + N + 2;
            if (b >= N + 2) b = b - (N + 2);
        end
        return SEL_W'(b);
    endfunction

    function automatic logic [SEL_W-1:0] result_bank(input logic [SEL_W-1:0] i,
                                                     input logic [SUB_W-1:0] z);
        int b;
        b = int'(i) - 2 * int'(z) + N + 2;
        if (b >= N + 2) b = b - (N + 2);
        return SEL_W'(b);
    endfunction

    function automatic logic [N+1:0] wb_mask(input logic [SUB_W-1:0] z);
        logic [N+1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[result_bank(SEL_W'(i), z)] = 1'b1;
        return m;
    endfunction

    logic [SEL_W-1:0] cur_bank;
    logic             col_last;
    logic             load_last;
    logic             run_wb;

    assign cur_bank  = load_bank(idx, substate, load_full);
    assign col_last  = (col == width_r - 1'b1);
    assign load_last = (idx == SEL_W'(load_full ? N + 1 : N - 1));
    assign run_wb    = (state == S_RUN) && (run_cnt >= RUN_W'(CONV_LAT + 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            substate     <= '0;
            full         <= 1'b1;
            load_full    <= 1'b0;
            idx          <= '0;
            col          <= '0;
            width_r      <= '0;
            run_cnt      <= '0;
            sel_q        <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state   <= S_LOAD;
                        width_r <= i_width;
                        col     <= '0;
                        idx     <= '0;
                        if (full || i_restart) begin
                            substate  <= '0;
                            load_full <= 1'b1;
                        end else begin
                            substate  <= (substate == SUB_W'(N / 2)) ? '0 : substate + 1'b1;
                            load_full <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_valid) begin
                        if (col_last) begin
                            col <= '0;
                            if (load_last) begin
                                state   <= S_RUN;
                                full    <= 1'b0;
                                run_cnt <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (run_cnt == RUN_W'(width_r) + RUN_W'(CONV_LAT)) begin
                        state <= S_READ;
                        col   <= '0;
                        idx   <= '0;
                        sel_q <= result_bank('0, substate);
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (i_rd_ready) begin
                        data_valid_q <= 1'b1;
                        sel_q        <= result_bank(idx, substate);
                        if (col_last) begin
                            col <= '0;
                            idx <= idx + 1'b1;
                            if (idx == SEL_W'(N - 1)) begin
                                state  <= S_DRAIN;
                                done_q <= 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The load write path is gated directly by i_valid so the pixel lands in the bank the cycle it is presented.
    always_comb begin
        o_state      = 2'b00;
        o_memSelect  = '0;
        o_wr_en      = '0;
        o_wr_addr    = '0;
        o_rd_addr    = '0;
        o_conv_valid = 1'b0;
        case (state)
            S_LOAD: begin
                o_memSelect = cur_bank;
                o_wr_addr   = col;
                if (i_valid) o_wr_en = {{(N + 1){1'b0}}, 1'b1} << cur_bank;
            end
            S_RUN: begin
                o_state = 2'b01;
                if (run_cnt < RUN_W'(width_r)) o_rd_addr = BITS_ADDR'(run_cnt);
                o_conv_valid = (run_cnt != '0) && (run_cnt <= RUN_W'(width_r));
                if (run_wb) begin
                    o_wr_en   = wb_mask(substate);
                    o_wr_addr = BITS_ADDR'(run_cnt - RUN_W'(CONV_LAT + 1));
                end
            end
            S_READ, S_DRAIN: begin
                o_state     = 2'b10;
                o_memSelect = sel_q;
                o_rd_addr   = col;
            end
            default: ;
        endcase
    end

    assign o_substate   = substate;
    assign o_ready      = (state == S_LOAD);
    assign o_data_valid = data_valid_q;
    assign o_busy       = (state != S_IDLE);
    assign o_done       = done_q;
endmodule

// File: tb/tb_mcu_bank_sequencer.sv
// tb/tb_mcu_bank_sequencer.sv - directed vector bench for mcu_bank_sequencer
module tb_mcu_bank_sequencer;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, restart, valid, rd_ready;
    logic [9:0] width;
    logic [1:0] o_state;
    logic       o_substate;
    logic [1:0] o_memSelect;
    logic [3:0] o_wr_en;
    logic [9:0] o_wr_addr, o_rd_addr;
    logic       o_conv_valid, o_ready, o_data_valid, o_busy, o_done;

    always #5 clk = ~clk;

    mcu_bank_sequencer #(.N(2), .BITS_ADDR(10), .CONV_LAT(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_restart(restart),
        .i_width(width), .i_valid(valid), .i_rd_ready(rd_ready),
        .o_state(o_state), .o_substate(o_substate), .o_memSelect(o_memSelect),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_rd_addr(o_rd_addr),
        .o_conv_valid(o_conv_valid), .o_ready(o_ready), .o_data_valid(o_data_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct packed {
        logic       st, rs, v, rr;
        logic [1:0] state;
        logic       sub;
        logic [1:0] sel;
        logic [3:0] we;
        logic [9:0] wa, ra;
        logic       cv, rdy, dv, busy, done;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [33:0] outs();
        return {o_state, o_substate, o_memSelect, o_wr_en, o_wr_addr, o_rd_addr,
                o_conv_valid, o_ready, o_data_valid, o_busy, o_done};
    endfunction

    function automatic string fmt(input logic [33:0] x);
        return $sformatf("state=%0d sub=%0d sel=%0d we=%b wa=%0d ra=%0d cv=%b rdy=%b dv=%b busy=%b done=%b",
                         x[33:32], x[31], x[30:29], x[28:25], x[24:15], x[14:5],
                         x[4], x[3], x[2], x[1], x[0]);
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic add(input int st, input int rs, input int v, input int rr,
                       input int state, input int sub, input int sel, input int we,
                       input int wa, input int ra, input int cv, input int rdy,
                       input int dv, input int busy, input int done);
        vec_t t;
        t.st = 1'(st);  t.rs = 1'(rs);  t.v = 1'(v);  t.rr = 1'(rr);
        t.state = 2'(state);  t.sub = 1'(sub);  t.sel = 2'(sel);  t.we = 4'(we);
        t.wa = 10'(wa);  t.ra = 10'(ra);
        t.cv = 1'(cv);  t.rdy = 1'(rdy);  t.dv = 1'(dv);  t.busy = 1'(busy);  t.done = 1'(done);
        vq.push_back(t);
    endtask

    task automatic gen_start(input int rs, input int sub_before);
        add(1, rs, 0, 0, 0, sub_before, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Loads nb consecutive banks starting at b0; gap inserts one i_valid-low cycle before pixel gap.
    task automatic gen_load(input int nb, input int b0, input int sub, input int gap);
        for (int p = 0; p < nb * W; p++) begin
            int bank;
            bank = b0 + p / W;
            if (p == gap) add(0, 0, 0, 0, 0, sub, bank, 0, p % W, 0, 0, 1, 0, 1, 0);
            add(0, 0, 1, 0, 0, sub, bank, 1 << bank, p % W, 0, 0, 1, 0, 1, 0);
        end
    endtask

    // Stray i_valid early in RUN and a stray i_start mid-RUN must both be ignored.
    task automatic gen_run(input int sub, input int mask);
        for (int r = 0; r < W + 1 + 4; r++)
            add(r == 3, 0, r < 3, 0, 1, sub, 0, r >= 5 ? mask : 0, r >= 5 ? r - 5 : 0,
                r < 4 ? r : 0, (r >= 1 && r <= 4), 0, 0, 1, 0);
    endtask

    task automatic gen_read(input int rb0, input int rb1, input int sub, input int gap_j);
        int   issued = 0;
        int   j = 0;
        int   sel = rb0;
        int   dvq = 0;
        int   rr;
        while (issued < 2 * W) begin
            rr = (j != gap_j) ? 1 : 0;
            add(0, 0, 0, rr, 2, sub, sel, 0, 0, issued % W, 0, 0, dvq, 1, 0);
            if (rr == 1) begin
                sel = (issued < W) ? rb0 : rb1;
                issued++;
                dvq = 1;
            end else begin
                dvq = 0;
            end
            j++;
        end
        add(0, 0, 0, 1, 2, sub, sel, 0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, sub, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_queue(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            start    = vq[i].st;
            restart  = vq[i].rs;
            valid    = vq[i].v;
            rd_ready = vq[i].rr;
            #1;
            check($sformatf("%s[%0d]", tag, i), outs(),
                  {vq[i].state, vq[i].sub, vq[i].sel, vq[i].we, vq[i].wa, vq[i].ra,
                   vq[i].cv, vq[i].rdy, vq[i].dv, vq[i].busy, vq[i].done});
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b1;  start = 1'b0;  restart = 1'b0;  valid = 1'b0;  rd_ready = 1'b0;
        width = 10'd4;
        @(negedge clk);
        @(negedge clk);
        check("reset", outs(), 34'd0);
        rst = 1'b0;

        gen_start(1, 0);
        gen_load(4, 0, 0, -1);
        gen_run(0, 4'b0011);
        gen_read(0, 1, 0, 1);
        run_queue("full_pass");

        gen_start(0, 0);
        gen_load(2, 0, 1, 5);
        gen_run(1, 4'b1100);
        gen_read(2, 3, 1, -1);
        run_queue("incr_pass");

        gen_start(0, 1);
        gen_load(2, 2, 0, -1);
        gen_run(0, 4'b0011);
        gen_read(0, 1, 0, -1);
        run_queue("wrap_pass");

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("reset_midload", outs(), 34'd0);
        @(negedge clk);
        check("reset_hold", outs(), 34'd0);
        rst = 1'b0;
        valid = 1'b0;

        gen_start(0, 0);
        gen_load(4, 0, 0, -1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_queue("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
